hash_result_serializer: RTL and testbench

Consumer-side endpoint of the hash engine output interface. It accepts one wide hash-result beat per handshake: a head address plus `HASH_ISSUE_WIDTH` per-position candidate slots. It filters the candidates and emits them one per cycle as scalar match requests to the downstream match scheduler. A delimited beat is followed by an explicit end-of-stream marker, so the downstream block can flush per-stream state.

---
 rtl/hash_result_serializer_pkg.sv | 20 ++
 rtl/hash_result_serializer_lowest_bit_select.sv | 25 ++
 rtl/hash_result_serializer.sv | 175 +++++++++++++++++
 tb/tb_hash_result_serializer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_result_serializer_pkg.sv
// rtl/hash_result_serializer_pkg.sv - shared widths and state encoding for the hash result serializer
package hash_result_serializer_pkg;

   localparam int HASH_ISSUE_WIDTH     = 16;
   localparam int ADDR_WIDTH           = 32;
   localparam int META_MATCH_LEN_WIDTH = 5;
   localparam int STAT_WIDTH           = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_EOS   = 2'd2
   } state_t;

   // Index width for a slot selector; at least one bit so single-slot builds still elaborate.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hash_result_serializer_lowest_bit_select.sv
// rtl/hash_result_serializer_lowest_bit_select.sv - lowest-set-bit priority encoder with one-hot mask and single-bit flag
module lowest_bit_select
   import hash_result_serializer_pkg::*;
#(
   parameter int N  = 16,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot,
   output logic          single
);

   // Scan from the top so the lowest set bit is the last one to write idx.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign onehot = req & (~req + N'(1));
   assign single = (req != '0) && ((req & (req - N'(1))) == '0);

endmodule

// File: rtl/hash_result_serializer.sv
// rtl/hash_result_serializer.sv - serializes filtered hash candidate beats into scalar match requests (optional stats: HASH_RESULT_SERIALIZER_STATS_EN)
module hash_result_serializer
   import hash_result_serializer_pkg::*;
#(
   parameter int HASH_ISSUE_WIDTH     = hash_result_serializer_pkg::HASH_ISSUE_WIDTH,
   parameter int ADDR_WIDTH           = hash_result_serializer_pkg::ADDR_WIDTH,
   parameter int META_MATCH_LEN_WIDTH = hash_result_serializer_pkg::META_MATCH_LEN_WIDTH
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic [META_MATCH_LEN_WIDTH-1:0]                cfg_min_match_len,
   input  logic                                           i_valid,
   output logic                                           i_ready,
   input  logic [ADDR_WIDTH-1:0]                          i_head_addr,
   input  logic [HASH_ISSUE_WIDTH-1:0]                    i_history_valid,
   input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]         i_history_addr,
   input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] i_meta_match_len,
   input  logic [HASH_ISSUE_WIDTH-1:0]                    i_meta_match_can_ext,
   input  logic                                           i_delim,
   output logic                                           o_valid,
   input  logic                                           o_ready,
   output logic                                           o_eos,
   output logic [ADDR_WIDTH-1:0]                          o_pos,
   output logic [ADDR_WIDTH-1:0]                          o_history_addr,
   output logic [ADDR_WIDTH-1:0]                          o_offset,
   output logic [META_MATCH_LEN_WIDTH-1:0]                o_meta_match_len,
   output logic                                           o_meta_match_can_ext
`ifdef HASH_RESULT_SERIALIZER_STATS_EN
   ,output logic [STAT_WIDTH-1:0]                         stat_beats
   ,output logic [STAT_WIDTH-1:0]                         stat_reqs
   ,output logic [STAT_WIDTH-1:0]                         stat_filtered
`endif
);

   localparam int W  = HASH_ISSUE_WIDTH;
   localparam int A  = ADDR_WIDTH;
   localparam int L  = META_MATCH_LEN_WIDTH;
   localparam int IW = idx_width(W);

   state_t          state_q, state_d;
   logic [W-1:0]    pend_q, pend_d, pass_vec, cap_pend;
   logic [A-1:0]    head_q;
   logic [W*A-1:0]  hist_q;
   logic [W*L-1:0]  len_q;
   logic [W-1:0]    ext_q;
   logic            delim_q;
   logic [IW-1:0]   sel_idx;
   logic [W-1:0]    sel_mask;
   logic            sel_single;
   logic            capture;

   lowest_bit_select #(.N(W), .IW(IW)) u_sel (
      .req    (pend_q),
      .idx    (sel_idx),
      .onehot (sel_mask),
      .single (sel_single)
   );

   // Per-slot length filter against the threshold seen at capture time.
   always_comb begin
      pass_vec = '0;
      for (int k = 0; k < W; k++) begin
         pass_vec[k] = i_meta_match_len[k*L +: L] >= cfg_min_match_len;
      end
   end

   assign cap_pend = i_history_valid & pass_vec;

   // Accept a beat when idle, or when this cycle's output handshake retires the beat's final record.
   assign i_ready = rst_n && ((state_q == ST_IDLE) ||
                              (state_q == ST_ISSUE && o_ready && sel_single && !delim_q) ||
                              (state_q == ST_EOS && o_ready));
   assign capture = i_valid && i_ready;

   // Output record: lowest pending slot in ISSUE, zero payload marker in EOS.
   always_comb begin
      o_valid              = 1'b0;
      o_eos                = 1'b0;
      o_pos                = '0;
      o_history_addr       = '0;
      o_offset             = '0;
      o_meta_match_len     = '0;
      o_meta_match_can_ext = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            o_valid              = 1'b1;
            o_pos                = head_q + A'(sel_idx);
            o_history_addr       = hist_q[sel_idx*A +: A];
            o_offset             = head_q + A'(sel_idx) - hist_q[sel_idx*A +: A];
            o_meta_match_len     = len_q[sel_idx*L +: L];
            o_meta_match_can_ext = ext_q[sel_idx];
         end
         ST_EOS: begin
            o_valid = 1'b1;
            o_eos   = 1'b1;
         end
         default: ;
      endcase
   end

   // Next state and pending mask; a capture in the same cycle overrides the retiring beat.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      case (state_q)
         ST_ISSUE: begin
            if (o_ready) begin
               pend_d = pend_q & ~sel_mask;
               if (sel_single) state_d = delim_q ? ST_EOS : ST_IDLE;
            end
         end
         ST_EOS: begin
            if (o_ready) state_d = ST_IDLE;
         end
         default: ;
      endcase
      if (capture) begin
         pend_d = cap_pend;
         if (cap_pend != '0) state_d = ST_ISSUE;
         else if (i_delim)   state_d = ST_EOS;
         else                state_d = ST_IDLE;
      end
   end

   // State, pending mask and captured beat registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         head_q  <= '0;
         hist_q  <= '0;
         len_q   <= '0;
         ext_q   <= '0;
         delim_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (capture) begin
            head_q  <= i_head_addr;
            hist_q  <= i_history_addr;
            len_q   <= i_meta_match_len;
            ext_q   <= i_meta_match_can_ext;
            delim_q <= i_delim;
         end
      end
   end

`ifdef HASH_RESULT_SERIALIZER_STATS_EN
   logic [IW:0]           filt_cnt;
   logic [STAT_WIDTH:0]   filt_sum;

   // Count candidates present but rejected by the length filter.
   always_comb begin
      filt_cnt = '0;
      for (int k = 0; k < W; k++) begin
         filt_cnt = filt_cnt + (IW+1)'(i_history_valid[k] & ~pass_vec[k]);
      end
      filt_sum = {1'b0, stat_filtered} + (STAT_WIDTH+1)'(filt_cnt);
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_beats    <= '0;
         stat_reqs     <= '0;
         stat_filtered <= '0;
      end else begin
         if (capture && stat_beats != '1) stat_beats <= stat_beats + 1'b1;
         if (o_valid && o_ready && !o_eos && stat_reqs != '1) stat_reqs <= stat_reqs + 1'b1;
         if (capture) stat_filtered <= filt_sum[STAT_WIDTH] ? '1 : filt_sum[STAT_WIDTH-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_hash_result_serializer.sv
// tb/tb_hash_result_serializer.sv - self-checking bench for hash_result_serializer against a record-list reference model
module tb_hash_result_serializer;

   localparam int W = 16;
   localparam int A = 32;
   localparam int L = 5;

   typedef struct packed {
      logic [A-1:0]   head;
      logic [W-1:0]   valid;
      logic [W*A-1:0] hist;
      logic [W*L-1:0] len;
      logic [W-1:0]   ext;
      logic           delim;
      logic [L-1:0]   min;
   } beat_t;

   typedef struct packed {
      logic         eos;
      logic [A-1:0] pos;
      logic [A-1:0] hist;
      logic [A-1:0] off;
      logic [L-1:0] len;
      logic         ext;
   } rec_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [L-1:0]   cfg_min_match_len;
   logic           i_valid;
   logic           i_ready;
   logic [A-1:0]   i_head_addr;
   logic [W-1:0]   i_history_valid;
   logic [W*A-1:0] i_history_addr;
   logic [W*L-1:0] i_meta_match_len;
   logic [W-1:0]   i_meta_match_can_ext;
   logic           i_delim;
   logic           o_valid;
   logic           o_ready;
   logic           o_eos;
   logic [A-1:0]   o_pos;
   logic [A-1:0]   o_history_addr;
   logic [A-1:0]   o_offset;
   logic [L-1:0]   o_meta_match_len;
   logic           o_meta_match_can_ext;
`ifdef HASH_RESULT_SERIALIZER_STATS_EN
   logic [31:0]    stat_beats, stat_reqs, stat_filtered;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   beat_t bq[$];
   rec_t  eq[$];
   longint m_beats = 0, m_reqs = 0, m_filtered = 0;

   always #5 clk = ~clk;

   hash_result_serializer dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .cfg_min_match_len    (cfg_min_match_len),
      .i_valid              (i_valid),
      .i_ready              (i_ready),
      .i_head_addr          (i_head_addr),
      .i_history_valid      (i_history_valid),
      .i_history_addr       (i_history_addr),
      .i_meta_match_len     (i_meta_match_len),
      .i_meta_match_can_ext (i_meta_match_can_ext),
      .i_delim              (i_delim),
      .o_valid              (o_valid),
      .o_ready              (o_ready),
      .o_eos                (o_eos),
      .o_pos                (o_pos),
      .o_history_addr       (o_history_addr),
      .o_offset             (o_offset),
      .o_meta_match_len     (o_meta_match_len),
      .o_meta_match_can_ext (o_meta_match_can_ext)
`ifdef HASH_RESULT_SERIALIZER_STATS_EN
      ,.stat_beats          (stat_beats)
      ,.stat_reqs           (stat_reqs)
      ,.stat_filtered       (stat_filtered)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: every valid slot whose length clears the threshold, ascending, then EOS if delimited.
   task automatic expand(input beat_t b);
      rec_t r;
      for (int k = 0; k < W; k++) begin
         if (b.valid[k] && (int'(b.len[k*L +: L]) >= int'(b.min))) begin
            r.eos  = 1'b0;
            r.pos  = A'(longint'(b.head) + k);
            r.hist = b.hist[k*A +: A];
            r.off  = A'(longint'(r.pos) - longint'(r.hist));
            r.len  = b.len[k*L +: L];
            r.ext  = b.ext[k];
            eq.push_back(r);
         end else if (b.valid[k]) begin
            m_filtered++;
         end
      end
      if (b.delim) begin
         r = '0;
         r.eos = 1'b1;
         eq.push_back(r);
      end
      m_beats++;
   endtask

   function automatic beat_t mk(input logic [A-1:0] head, input logic [W-1:0] valid,
                                input logic [L-1:0] len, input logic delim, input logic [L-1:0] min);
      beat_t b;
      b.head  = head;
      b.valid = valid;
      for (int k = 0; k < W; k++) begin
         b.hist[k*A +: A] = $urandom;
         b.len[k*L +: L]  = len;
      end
      b.ext   = W'($urandom);
      b.delim = delim;
      b.min   = min;
      return b;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t b;
      b = mk($urandom, W'($urandom | $urandom), '0, $urandom_range(0, 1) == 1, L'($urandom));
      if ($urandom_range(0, 5) == 0) b.valid = '0;
      for (int k = 0; k < W; k++) b.len[k*L +: L] = L'($urandom);
      return b;
   endfunction

   // Drive queued beats and drain expected records; checks every cycle against the model.
   task automatic run(input int mode, input int budget);
      int   cyc = 0;
      logic stall_prev = 1'b0;
      logic [102:0] prev = '0, cur;
      logic o_hs, i_hs;
      beat_t b;
      while ((bq.size() > 0 || eq.size() > 0) && cyc < budget) begin
         @(negedge clk);
         if (bq.size() > 0) begin
            i_valid              = 1'b1;
            i_head_addr          = bq[0].head;
            i_history_valid      = bq[0].valid;
            i_history_addr       = bq[0].hist;
            i_meta_match_len     = bq[0].len;
            i_meta_match_can_ext = bq[0].ext;
            i_delim              = bq[0].delim;
            cfg_min_match_len    = bq[0].min;
         end else begin
            i_valid           = 1'b0;
            cfg_min_match_len = L'($urandom);
         end
         o_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : ($urandom_range(0, 3) != 0);
         #1;
         check("o_valid", 64'(o_valid), 64'(eq.size() != 0));
         check("i_ready", 64'(i_ready), 64'(eq.size() == 0 || (o_ready && eq.size() == 1)));
         if (o_valid && eq.size() > 0) begin
            check("o_eos",       64'(o_eos),                64'(eq[0].eos));
            check("o_pos",       64'(o_pos),                64'(eq[0].pos));
            check("o_hist",      64'(o_history_addr),       64'(eq[0].hist));
            check("o_offset",    64'(o_offset),             64'(eq[0].off));
            check("o_len",       64'(o_meta_match_len),     64'(eq[0].len));
            check("o_can_ext",   64'(o_meta_match_can_ext), 64'(eq[0].ext));
         end
         cur = {o_eos, o_pos, o_history_addr, o_offset, o_meta_match_len, o_meta_match_can_ext};
         if (stall_prev) check("stall_stable", 64'(cur == prev), 64'd1);
         o_hs       = o_valid && o_ready;
         i_hs       = i_valid && i_ready;
         stall_prev = o_valid && !o_ready;
         prev       = cur;
         @(posedge clk);
         if (o_hs && eq.size() > 0) begin
            if (!eq[0].eos) m_reqs++;
            void'(eq.pop_front());
         end
         if (i_hs && bq.size() > 0) begin
            b = bq.pop_front();
            expand(b);
         end
         cyc++;
      end
      check("run_drained", 64'(bq.size() == 0 && eq.size() == 0), 64'd1);
      @(negedge clk);
      i_valid = 1'b0;
      o_ready = 1'b1;
`ifdef HASH_RESULT_SERIALIZER_STATS_EN
      #1;
      check("stat_beats",    64'(stat_beats),    64'(m_beats));
      check("stat_reqs",     64'(stat_reqs),     64'(m_reqs));
      check("stat_filtered", 64'(stat_filtered), 64'(m_filtered));
`endif
   endtask

   initial begin
      beat_t b;
      rst_n = 1'b0;
      i_valid = 1'b0; o_ready = 1'b1; cfg_min_match_len = '0;
      i_head_addr = '0; i_history_valid = '0; i_history_addr = '0;
      i_meta_match_len = '0; i_meta_match_can_ext = '0; i_delim = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_i_ready", 64'(i_ready), 64'd0);
      check("rst_o_valid", 64'(o_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_i_ready", 64'(i_ready), 64'd1);
      check("post_rst_o_valid", 64'(o_valid), 64'd0);
      check("post_rst_o_eos",   64'(o_eos),   64'd0);
      check("post_rst_o_pos",   64'(o_pos),   64'd0);

      // Two records, no delim
      bq.push_back(mk(32'h100, 16'h0005, 5'd8, 1'b0, 5'd4));
      run(0, 50);

      // Slot 2 filtered out
      b = mk(32'h100, 16'h0005, 5'd8, 1'b0, 5'd4);
      b.len[2*L +: L] = 5'd3;
      bq.push_back(b);
      run(0, 50);

      // Empty delimited beat yields only EOS
      bq.push_back(mk(32'h200, 16'h0000, 5'd8, 1'b1, 5'd4));
      run(0, 50);

      // Edge slots with delim under toggling o_ready
      bq.push_back(mk(32'h300, 16'h8001, 5'd8, 1'b1, 5'd4));
      run(1, 50);

      // Address wrap
      b = mk(32'hFFFF_FFFE, 16'h0008, 5'd8, 1'b0, 5'd4);
      b.hist[3*A +: A] = 32'hFFFF_FFF0;
      bq.push_back(b);
      run(0, 50);

      // Back-to-back beats including a silent one and threshold edges
      bq.push_back(mk(32'h400, 16'h0003, 5'd4, 1'b0, 5'd4));
      bq.push_back(mk(32'h500, 16'h00F0, 5'd3, 1'b0, 5'd4));
      bq.push_back(mk(32'h600, 16'hC000, 5'd31, 1'b1, 5'd31));
      bq.push_back(mk(32'h700, 16'h0001, 5'd0, 1'b0, 5'd0));
      run(0, 100);

      // Reset while in ISSUE with three slots pending
      @(negedge clk);
      i_head_addr = 32'h800; i_history_valid = 16'h0007; i_meta_match_len = '1;
      i_delim = 1'b1; cfg_min_match_len = '0; i_valid = 1'b1; o_ready = 1'b0;
      #1;
      check("mid_rst_capture_ready", 64'(i_ready), 64'd1);
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      check("mid_rst_issue_valid", 64'(o_valid), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_o_valid", 64'(o_valid), 64'd0);
      rst_n = 1'b1;
      o_ready = 1'b1;
      m_beats = 0; m_reqs = 0; m_filtered = 0;
      #1;
      check("mid_rst_i_ready", 64'(i_ready), 64'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         check("mid_rst_no_stale", 64'(o_valid), 64'd0);
      end

      // Random beats with random backpressure and threshold churn
      for (int n = 0; n < 60; n++) bq.push_back(rnd_beat());
      run(2, 4000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
